// File: rtl/esaxi_rd_engine.sv
// esaxi_rd_engine: AXI4 slave read-channel engine for the Emesh AXI slave bridge.
// Queues AR commands, issues one backend read per beat (one outstanding at a time),
// and returns R beats with ID, RLAST and RRESP. Supports FIXED/INCR/WRAP bursts,
// narrow transfers with byte-lane replication, and 32- or 64-bit data.
// Optional feature macro: ESAXI_RD_WRAP_EN. When defined, WRAP bursts are supported;
// when undefined, WRAP bursts are classified illegal and answered with SLVERR.
module esaxi_rd_engine #(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ID_W     = 12,
  parameter int unsigned AR_DEPTH = 2
) (
  input  logic              clk,
  input  logic              s_axi_aresetn,
  // AR channel
  input  logic [ID_W-1:0]   s_axi_arid,
  input  logic [ADDR_W-1:0] s_axi_araddr,
  input  logic [7:0]        s_axi_arlen,
  input  logic [2:0]        s_axi_arsize,
  input  logic [1:0]        s_axi_arburst,
  input  logic              s_axi_arvalid,
  output logic              s_axi_arready,
  // R channel
  output logic [ID_W-1:0]   s_axi_rid,
  output logic [DATA_W-1:0] s_axi_rdata,
  output logic [1:0]        s_axi_rresp,
  output logic              s_axi_rlast,
  output logic              s_axi_rvalid,
  input  logic              s_axi_rready,
  // Backend read request / response
  output logic              rd_req_valid,
  input  logic              rd_req_ready,
  output logic [ADDR_W-1:0] rd_req_addr,
  output logic [2:0]        rd_req_size,
  input  logic              rd_rsp_valid,
  input  logic [DATA_W-1:0] rd_rsp_data,
  input  logic [1:0]        rd_rsp_resp,
  // Status
  output logic              busy
);

  localparam int unsigned     PtrW    = (AR_DEPTH > 1) ? $clog2(AR_DEPTH) : 1;
  localparam int unsigned     CntW    = $clog2(AR_DEPTH + 1);
  localparam int unsigned     EntW    = ID_W + ADDR_W + 8 + 3 + 2;
  localparam logic [2:0]      MaxSize = (DATA_W == 64) ? 3'd3 : 3'd2;
  localparam logic [PtrW-1:0] LastPtr = PtrW'(AR_DEPTH - 1);
  localparam logic [CntW-1:0] FullCnt = CntW'(AR_DEPTH);

  localparam logic [1:0] BurstFixed = 2'b00;
  localparam logic [1:0] BurstIncr  = 2'b01;
  localparam logic [1:0] BurstWrap  = 2'b10;
  localparam logic [1:0] BurstRsvd  = 2'b11;
  localparam logic [1:0] RespSlverr = 2'b10;

  typedef enum logic [1:0] {StIdle, StReq, StWait, StResp} state_e;

  // ---------------------------------------------------------------------------
  // AR command queue
  // ---------------------------------------------------------------------------
  logic [EntW-1:0] q_mem [AR_DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] count_q;
  logic            init_q;
  logic            q_full, q_empty, q_push, q_pop;

  state_e          state_q;

  assign q_full        = (count_q == FullCnt);
  assign q_empty       = (count_q == '0);
  // init_q keeps arready low until the first clock edge after reset release.
  assign s_axi_arready = init_q & ~q_full;
  assign q_push        = s_axi_arvalid & s_axi_arready;
  assign q_pop         = (state_q == StIdle) & ~q_empty;

  // Queue pointers, occupancy and the post-reset arready enable.
  always_ff @(posedge clk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      init_q   <= 1'b0;
    end else begin
      init_q <= 1'b1;
      if (q_push) begin
        wr_ptr_q <= (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + PtrW'(1);
      end
      if (q_pop) begin
        rd_ptr_q <= (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + PtrW'(1);
      end
      if (q_push && !q_pop) begin
        count_q <= count_q + CntW'(1);
      end else if (!q_push && q_pop) begin
        count_q <= count_q - CntW'(1);
      end
    end
  end

  // Queue storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (q_push) begin
      q_mem[wr_ptr_q] <= {s_axi_arid, s_axi_araddr, s_axi_arlen, s_axi_arsize, s_axi_arburst};
    end
  end

  logic [ID_W-1:0]   h_id;
  logic [ADDR_W-1:0] h_addr;
  logic [7:0]        h_len;
  logic [2:0]        h_size;
  logic [1:0]        h_burst;
  logic              h_illegal;

  assign {h_id, h_addr, h_len, h_size, h_burst} = q_mem[rd_ptr_q];

  // Classify the head command: reserved burst, oversize beat, or bad WRAP length.
  always_comb begin
    h_illegal = 1'b0;
    if (h_burst == BurstRsvd) begin
      h_illegal = 1'b1;
    end
    if (h_size > MaxSize) begin
      h_illegal = 1'b1;
    end
`ifdef ESAXI_RD_WRAP_EN
    if ((h_burst == BurstWrap) &&
        (h_len != 8'd1) && (h_len != 8'd3) && (h_len != 8'd7) && (h_len != 8'd15)) begin
      h_illegal = 1'b1;
    end
`else
    if (h_burst == BurstWrap) begin
      h_illegal = 1'b1;
    end
`endif
  end

  // ---------------------------------------------------------------------------
  // Burst state
  // ---------------------------------------------------------------------------
  logic [ID_W-1:0]   b_id_q;
  logic [ADDR_W-1:0] b_addr_q;
  logic [2:0]        b_size_q;
  logic [1:0]        b_burst_q;
  logic [7:0]        beat_cnt_q;
  logic              err_q;
`ifdef ESAXI_RD_WRAP_EN
  logic [7:0]        b_len_q;
  logic [ADDR_W-1:0] wrap_bound;
`endif
  logic              req_valid_q;
  logic              rvalid_q;
  logic              rlast_q;
  logic [DATA_W-1:0] rdata_q;
  logic [1:0]        rresp_q;

  logic [ADDR_W-1:0] incr;
  logic [ADDR_W-1:0] next_addr;
  logic [DATA_W-1:0] repl_data;

  // Address of the next beat; INCR aligns to the beat size before stepping.
  always_comb begin
    incr      = ADDR_W'(1) << b_size_q;
    next_addr = b_addr_q;
`ifdef ESAXI_RD_WRAP_EN
    wrap_bound = (ADDR_W'(b_len_q) + ADDR_W'(1)) << b_size_q;
`endif
    case (b_burst_q)
      BurstIncr: next_addr = (b_addr_q & ~(incr - ADDR_W'(1))) + incr;
`ifdef ESAXI_RD_WRAP_EN
      BurstWrap: next_addr = (b_addr_q & ~(wrap_bound - ADDR_W'(1))) |
                             ((b_addr_q + incr) & (wrap_bound - ADDR_W'(1)));
`endif
      BurstFixed: next_addr = b_addr_q;
      default:    next_addr = b_addr_q;
    endcase
  end

  // Replicate the right-justified backend data across all byte lanes.
  always_comb begin
    case (b_size_q)
      3'd0:    repl_data = {(DATA_W / 8){rd_rsp_data[7:0]}};
      3'd1:    repl_data = {(DATA_W / 16){rd_rsp_data[15:0]}};
      3'd2:    repl_data = {(DATA_W / 32){rd_rsp_data[31:0]}};
      default: repl_data = rd_rsp_data;
    endcase
  end

  // Read engine FSM with registered handshake and R-channel outputs.
  always_ff @(posedge clk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      state_q     <= StIdle;
      b_id_q      <= '0;
      b_addr_q    <= '0;
      b_size_q    <= '0;
      b_burst_q   <= '0;
`ifdef ESAXI_RD_WRAP_EN
      b_len_q     <= '0;
`endif
      beat_cnt_q  <= '0;
      err_q       <= 1'b0;
      req_valid_q <= 1'b0;
      rvalid_q    <= 1'b0;
      rlast_q     <= 1'b0;
      rdata_q     <= '0;
      rresp_q     <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (!q_empty) begin
            b_id_q     <= h_id;
            b_addr_q   <= h_addr;
            b_size_q   <= h_size;
            b_burst_q  <= h_burst;
`ifdef ESAXI_RD_WRAP_EN
            b_len_q    <= h_len;
`endif
            beat_cnt_q <= h_len;
            if (h_illegal) begin
              // Error mode: answer every beat locally, never touch the backend.
              err_q    <= 1'b1;
              rvalid_q <= 1'b1;
              rlast_q  <= (h_len == 8'd0);
              rdata_q  <= '0;
              rresp_q  <= RespSlverr;
              state_q  <= StResp;
            end else begin
              err_q       <= 1'b0;
              req_valid_q <= 1'b1;
              state_q     <= StReq;
            end
          end
        end
        StReq: begin
          if (rd_req_ready) begin
            req_valid_q <= 1'b0;
            state_q     <= StWait;
          end
        end
        StWait: begin
          if (rd_rsp_valid) begin
            rdata_q  <= repl_data;
            rresp_q  <= rd_rsp_resp;
            rvalid_q <= 1'b1;
            rlast_q  <= (beat_cnt_q == 8'd0);
            state_q  <= StResp;
          end
        end
        StResp: begin
          if (s_axi_rready) begin
            if (beat_cnt_q == 8'd0) begin
              rvalid_q <= 1'b0;
              rlast_q  <= 1'b0;
              err_q    <= 1'b0;
              state_q  <= StIdle;
            end else begin
              beat_cnt_q <= beat_cnt_q - 8'd1;
              b_addr_q   <= next_addr;
              rlast_q    <= (beat_cnt_q == 8'd1);
              if (!err_q) begin
                rvalid_q    <= 1'b0;
                req_valid_q <= 1'b1;
                state_q     <= StReq;
              end
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign rd_req_valid = req_valid_q;
  assign rd_req_addr  = b_addr_q;
  assign rd_req_size  = b_size_q;
  assign s_axi_rid    = b_id_q;
  assign s_axi_rdata  = rdata_q;
  assign s_axi_rresp  = rresp_q;
  assign s_axi_rlast  = rlast_q;
  assign s_axi_rvalid = rvalid_q;
  assign busy         = ~q_empty | (state_q != StIdle);

endmodule

// File: tb/tb_esaxi_rd_engine.sv
// Scoreboard bench for esaxi_rd_engine (default parameters: 32-bit data, 12-bit ID, depth 2).
`timescale 1ns/1ps
module tb_esaxi_rd_engine;

  logic        clk = 1'b0;
  logic        s_axi_aresetn;
  logic [11:0] s_axi_arid;
  logic [31:0] s_axi_araddr;
  logic [7:0]  s_axi_arlen;
  logic [2:0]  s_axi_arsize;
  logic [1:0]  s_axi_arburst;
  logic        s_axi_arvalid;
  logic        s_axi_arready;
  logic [11:0] s_axi_rid;
  logic [31:0] s_axi_rdata;
  logic [1:0]  s_axi_rresp;
  logic        s_axi_rlast;
  logic        s_axi_rvalid;
  logic        s_axi_rready;
  logic        rd_req_valid;
  logic        rd_req_ready;
  logic [31:0] rd_req_addr;
  logic [2:0]  rd_req_size;
  logic        rd_rsp_valid;
  logic [31:0] rd_rsp_data;
  logic [1:0]  rd_rsp_resp;
  logic        busy;

  always #5 clk = ~clk;

  esaxi_rd_engine dut (
    .clk           (clk),
    .s_axi_aresetn (s_axi_aresetn),
    .s_axi_arid    (s_axi_arid),
    .s_axi_araddr  (s_axi_araddr),
    .s_axi_arlen   (s_axi_arlen),
    .s_axi_arsize  (s_axi_arsize),
    .s_axi_arburst (s_axi_arburst),
    .s_axi_arvalid (s_axi_arvalid),
    .s_axi_arready (s_axi_arready),
    .s_axi_rid     (s_axi_rid),
    .s_axi_rdata   (s_axi_rdata),
    .s_axi_rresp   (s_axi_rresp),
    .s_axi_rlast   (s_axi_rlast),
    .s_axi_rvalid  (s_axi_rvalid),
    .s_axi_rready  (s_axi_rready),
    .rd_req_valid  (rd_req_valid),
    .rd_req_ready  (rd_req_ready),
    .rd_req_addr   (rd_req_addr),
    .rd_req_size   (rd_req_size),
    .rd_rsp_valid  (rd_rsp_valid),
    .rd_rsp_data   (rd_rsp_data),
    .rd_rsp_resp   (rd_rsp_resp),
    .busy          (busy)
  );

  typedef struct packed {
    logic [11:0] id;
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
  } beat_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [2:0]  size;
  } req_t;

  beat_t       exp_r[$];
  req_t        exp_req[$];
  logic [31:0] bdata[$];
  logic [1:0]  bresp[$];

  int total = 0;
  int bad   = 0;
  int rr_mode = 0;   // 0: rready=1, 1: toggle, 2: rready=0, 3: driven by test
  bit req_stall = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  task automatic fail_event(input string name);
    total++;
    bad++;
    $display("FAIL %s: got no match required an expected event", name);
  endtask

  task automatic exp_beat(input logic [11:0] id, input logic [31:0] d, input logic [1:0] rs,
                          input logic last);
    beat_t b;
    b.id = id; b.data = d; b.resp = rs; b.last = last;
    exp_r.push_back(b);
  endtask

  task automatic exp_rq(input logic [31:0] a, input logic [2:0] sz, input logic [31:0] d,
                        input logic [1:0] rs);
    req_t r;
    r.addr = a; r.size = sz;
    exp_req.push_back(r);
    bdata.push_back(d);
    bresp.push_back(rs);
  endtask

  // Must be called just after a rising edge (posedge + #1).
  task automatic send_ar(input logic [11:0] id, input logic [31:0] a, input logic [7:0] len,
                         input logic [2:0] sz, input logic [1:0] bu);
    int n;
    s_axi_arid = id; s_axi_araddr = a; s_axi_arlen = len;
    s_axi_arsize = sz; s_axi_arburst = bu; s_axi_arvalid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!s_axi_arready && n < 300);
    if (!s_axi_arready) fail_event("ar_accept_timeout");
    @(posedge clk);
    #1;
    s_axi_arvalid = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while ((exp_r.size() != 0 || busy) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check({name, "_beats_left"}, 64'(exp_r.size()), 64'd0);
    check({name, "_busy"}, 64'(busy), 64'd0);
    check({name, "_reqs_left"}, 64'(exp_req.size()), 64'd0);
  endtask

  task automatic wait_rvalid(input string name);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!s_axi_rvalid && n < 300);
    if (!s_axi_rvalid) fail_event(name);
  endtask

  // rready / rd_req_ready drivers, updated just after each rising edge.
  initial begin
    s_axi_rready = 1'b1;
    rd_req_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rr_mode)
        0: s_axi_rready = 1'b1;
        1: s_axi_rready = ~s_axi_rready;
        2: s_axi_rready = 1'b0;
        default: ;
      endcase
      rd_req_ready = req_stall ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Backend model: checks each request and answers it one cycle later.
  initial begin
    req_t r;
    rd_rsp_valid = 1'b0;
    rd_rsp_data  = '0;
    rd_rsp_resp  = '0;
    forever begin
      @(negedge clk);
      if (s_axi_aresetn && rd_req_valid && rd_req_ready) begin
        if (exp_req.size() == 0) begin
          fail_event("unexpected_backend_req");
        end else begin
          r = exp_req.pop_front();
          check("req_addr", 64'(rd_req_addr), 64'(r.addr));
          check("req_size", 64'(rd_req_size), 64'(r.size));
        end
        @(negedge clk);
        if (bdata.size() != 0) begin
          rd_rsp_data = bdata.pop_front();
          rd_rsp_resp = bresp.pop_front();
        end else begin
          rd_rsp_data = 32'hDEAD_BEEF;
          rd_rsp_resp = 2'b00;
        end
        rd_rsp_valid = 1'b1;
        @(negedge clk);
        rd_rsp_valid = 1'b0;
        if (s_axi_aresetn) check("rvalid_latency", 64'(s_axi_rvalid), 64'd1);
      end
    end
  end

  // R monitor: pops the scoreboard on each handshake and checks hold during stalls.
  initial begin
    beat_t       e;
    bit          stalled;
    logic [47:0] held;
    stalled = 1'b0;
    held    = '0;
    forever begin
      @(negedge clk);
      if (!s_axi_aresetn) begin
        stalled = 1'b0;
      end else begin
        if (stalled) begin
          check("r_hold", 64'({s_axi_rvalid, s_axi_rid, s_axi_rdata, s_axi_rresp, s_axi_rlast}),
                64'(held));
        end
        if (s_axi_rvalid && s_axi_rready) begin
          if (exp_r.size() == 0) begin
            fail_event("unexpected_r_beat");
          end else begin
            e = exp_r.pop_front();
            check("rid", 64'(s_axi_rid), 64'(e.id));
            check("rdata", 64'(s_axi_rdata), 64'(e.data));
            check("rresp", 64'(s_axi_rresp), 64'(e.resp));
            check("rlast", 64'(s_axi_rlast), 64'(e.last));
          end
        end
        stalled = s_axi_rvalid && !s_axi_rready;
        held    = {s_axi_rvalid, s_axi_rid, s_axi_rdata, s_axi_rresp, s_axi_rlast};
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    s_axi_aresetn = 1'b0;
    s_axi_arvalid = 1'b0;
    s_axi_arid = '0; s_axi_araddr = '0; s_axi_arlen = '0;
    s_axi_arsize = '0; s_axi_arburst = '0;
    repeat (3) @(negedge clk);
    check("reset_outputs", 64'({s_axi_arready, s_axi_rvalid, s_axi_rlast, s_axi_rid, s_axi_rresp,
                                rd_req_valid, rd_req_size, busy}), 64'd0);
    check("reset_rdata", 64'(s_axi_rdata), 64'd0);
    check("reset_req_addr", 64'(rd_req_addr), 64'd0);
    s_axi_aresetn = 1'b1;
    #1;
    check("arready_before_edge", 64'(s_axi_arready), 64'd0);
    @(negedge clk);
    check("arready_after_edge", 64'(s_axi_arready), 64'd1);
    check("busy_idle", 64'(busy), 64'd0);

    // INCR len=3 size=2 with request latency check
    exp_rq(32'h1000, 3'd2, 32'h0000_00A0, 2'b00);
    exp_rq(32'h1004, 3'd2, 32'h0000_00A1, 2'b00);
    exp_rq(32'h1008, 3'd2, 32'h0000_00A2, 2'b00);
    exp_rq(32'h100C, 3'd2, 32'h0000_00A3, 2'b00);
    exp_beat(12'h123, 32'h0000_00A0, 2'b00, 1'b0);
    exp_beat(12'h123, 32'h0000_00A1, 2'b00, 1'b0);
    exp_beat(12'h123, 32'h0000_00A2, 2'b00, 1'b0);
    exp_beat(12'h123, 32'h0000_00A3, 2'b00, 1'b1);
    @(posedge clk); #1;
    send_ar(12'h123, 32'h1000, 8'd3, 3'd2, 2'b01);
    @(negedge clk);
    check("req_valid_cycle1", 64'(rd_req_valid), 64'd0);
    @(negedge clk);
    check("req_valid_cycle2", 64'(rd_req_valid), 64'd1);
    wait_done("incr");

    // WRAP len=3 size=2 from 0x2008
`ifdef ESAXI_RD_WRAP_EN
    exp_rq(32'h2008, 3'd2, 32'h0000_00B0, 2'b00);
    exp_rq(32'h200C, 3'd2, 32'h0000_00B1, 2'b00);
    exp_rq(32'h2000, 3'd2, 32'h0000_00B2, 2'b00);
    exp_rq(32'h2004, 3'd2, 32'h0000_00B3, 2'b00);
    exp_beat(12'h02A, 32'h0000_00B0, 2'b00, 1'b0);
    exp_beat(12'h02A, 32'h0000_00B1, 2'b00, 1'b0);
    exp_beat(12'h02A, 32'h0000_00B2, 2'b00, 1'b0);
    exp_beat(12'h02A, 32'h0000_00B3, 2'b00, 1'b1);
`else
    exp_beat(12'h02A, 32'h0, 2'b10, 1'b0);
    exp_beat(12'h02A, 32'h0, 2'b10, 1'b0);
    exp_beat(12'h02A, 32'h0, 2'b10, 1'b0);
    exp_beat(12'h02A, 32'h0, 2'b10, 1'b1);
`endif
    @(posedge clk); #1;
    send_ar(12'h02A, 32'h2008, 8'd3, 3'd2, 2'b10);
    wait_done("wrap");

    // Narrow reads with lane replication; backend SLVERR passes through
    exp_rq(32'h3001, 3'd0, 32'h0000_005A, 2'b00);
    exp_beat(12'h031, 32'h5A5A_5A5A, 2'b00, 1'b1);
    exp_rq(32'h3002, 3'd1, 32'h0000_1234, 2'b10);
    exp_beat(12'h032, 32'h1234_1234, 2'b10, 1'b1);
    exp_rq(32'h3003, 3'd0, 32'hFFFF_FF77, 2'b00);
    exp_rq(32'h3004, 3'd0, 32'h0000_0088, 2'b00);
    exp_beat(12'h033, 32'h7777_7777, 2'b00, 1'b0);
    exp_beat(12'h033, 32'h8888_8888, 2'b00, 1'b1);
    @(posedge clk); #1;
    send_ar(12'h031, 32'h3001, 8'd0, 3'd0, 2'b01);
    send_ar(12'h032, 32'h3002, 8'd0, 3'd1, 2'b00);
    send_ar(12'h033, 32'h3003, 8'd1, 3'd0, 2'b01);
    wait_done("narrow");

    // Illegal: oversize beat and reserved burst type
    exp_beat(12'h044, 32'h0, 2'b10, 1'b0);
    exp_beat(12'h044, 32'h0, 2'b10, 1'b1);
    exp_beat(12'h045, 32'h0, 2'b10, 1'b1);
    @(posedge clk); #1;
    send_ar(12'h044, 32'h4400, 8'd1, 3'd3, 2'b01);
    send_ar(12'h045, 32'h4500, 8'd0, 3'd2, 2'b11);
    wait_done("illegal");

    // Queue depth: three back-to-back ARs while the first burst is stalled
    rr_mode = 2;
    exp_rq(32'h4000, 3'd2, 32'h0000_00D0, 2'b00);
    exp_rq(32'h4004, 3'd2, 32'h0000_00D1, 2'b00);
    exp_rq(32'h5000, 3'd2, 32'h0000_00D2, 2'b00);
    exp_rq(32'h6000, 3'd2, 32'h0000_00E0, 2'b00);
    exp_rq(32'h6000, 3'd2, 32'h0000_00E1, 2'b00);
    exp_beat(12'h001, 32'h0000_00D0, 2'b00, 1'b0);
    exp_beat(12'h001, 32'h0000_00D1, 2'b00, 1'b1);
    exp_beat(12'h002, 32'h0000_00D2, 2'b00, 1'b1);
    exp_beat(12'h003, 32'h0000_00E0, 2'b00, 1'b0);
    exp_beat(12'h003, 32'h0000_00E1, 2'b00, 1'b1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    send_ar(12'h001, 32'h4000, 8'd1, 3'd2, 2'b01);
    send_ar(12'h002, 32'h5000, 8'd0, 3'd2, 2'b01);
    send_ar(12'h003, 32'h6000, 8'd1, 3'd2, 2'b00);
    @(negedge clk);
    check("arready_full", 64'(s_axi_arready), 64'd0);
    repeat (4) @(negedge clk);
    check("arready_full_held", 64'(s_axi_arready), 64'd0);
    rr_mode = 0;
    wait_done("depth");
    check("arready_drained", 64'(s_axi_arready), 64'd1);

    // FIXED len=2 with rready toggling and random backend ready
    rr_mode = 1;
    req_stall = 1'b1;
    exp_rq(32'h7004, 3'd2, 32'h0000_00F0, 2'b00);
    exp_rq(32'h7004, 3'd2, 32'h0000_00F1, 2'b00);
    exp_rq(32'h7004, 3'd2, 32'h0000_00F2, 2'b00);
    exp_beat(12'h0F0, 32'h0000_00F0, 2'b00, 1'b0);
    exp_beat(12'h0F0, 32'h0000_00F1, 2'b00, 1'b0);
    exp_beat(12'h0F0, 32'h0000_00F2, 2'b00, 1'b1);
    @(posedge clk); #1;
    send_ar(12'h0F0, 32'h7004, 8'd2, 3'd2, 2'b00);
    wait_done("fixed");
    req_stall = 1'b0;
    rr_mode = 3;
    s_axi_rready = 1'b0;

    // Reset during beat 2 of a len=7 INCR burst
    exp_rq(32'h8000, 3'd2, 32'h0000_0090, 2'b00);
    exp_rq(32'h8004, 3'd2, 32'h0000_0091, 2'b00);
    exp_beat(12'h077, 32'h0000_0090, 2'b00, 1'b0);
    @(posedge clk); #1;
    send_ar(12'h077, 32'h8000, 8'd7, 3'd2, 2'b01);
    wait_rvalid("rst_beat1_timeout");
    @(posedge clk); #1;
    s_axi_rready = 1'b1;
    @(posedge clk); #1;
    s_axi_rready = 1'b0;
    wait_rvalid("rst_beat2_timeout");
    #2;
    s_axi_aresetn = 1'b0;
    #1;
    check("rst_rvalid", 64'(s_axi_rvalid), 64'd0);
    check("rst_req_valid", 64'(rd_req_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_arready", 64'(s_axi_arready), 64'd0);
    check("rst_beats_left", 64'(exp_r.size()), 64'd0);
    check("rst_reqs_left", 64'(exp_req.size()), 64'd0);
    repeat (2) @(negedge clk);
    s_axi_aresetn = 1'b1;
    #1;
    check("rel_arready_before_edge", 64'(s_axi_arready), 64'd0);
    @(negedge clk);
    check("rel_arready", 64'(s_axi_arready), 64'd1);
    check("rel_busy", 64'(busy), 64'd0);
    check("rel_rvalid", 64'(s_axi_rvalid), 64'd0);
    rr_mode = 0;
    exp_rq(32'h9000, 3'd2, 32'h0000_00C0, 2'b00);
    exp_rq(32'h9004, 3'd2, 32'h0000_00C1, 2'b00);
    exp_beat(12'h078, 32'h0000_00C0, 2'b00, 1'b0);
    exp_beat(12'h078, 32'h0000_00C1, 2'b00, 1'b1);
    @(posedge clk); #1;
    send_ar(12'h078, 32'h9000, 8'd1, 3'd2, 2'b01);
    wait_done("post_reset");

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/esaxi_rd_engine.md
# esaxi_rd_engine

Parametrised AXI4 slave read-channel engine for the Emesh AXI slave bridge. It queues up to AR_DEPTH read-address commands, issues one backend read per beat, and returns R beats with correct ID, RLAST and RRESP. It supports FIXED, INCR and WRAP bursts, narrow transfers with byte-lane replication, and 32- or 64-bit data. It sits between the AXI slave port and the Emesh read request/response path.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width; 32 or 64 only
- ID_W, 12, AXI ID width
- AR_DEPTH, 2, AR command queue depth; power of two, ≥1
- clk  in  1  single clock, rising edge
- s_axi_aresetn  in  1  reset, asynchronous, active-low
- s_axi_arid  in  ID_W  read ID
- s_axi_araddr  in  ADDR_W  start address
- s_axi_arlen  in  8  beats minus 1
- s_axi_arsize  in  3  log2 bytes per beat
- s_axi_arburst  in  2  00 FIXED, 01 INCR, 10 WRAP, 11 reserved
- s_axi_arvalid / s_axi_arready  in / out  1  AR handshake
- s_axi_rid  out  ID_W  ID of current beat
- s_axi_rdata  out  DATA_W  beat data
- s_axi_rresp  out  2  beat response
- s_axi_rlast  out  1  final beat of burst
- s_axi_rvalid / s_axi_rready  out / in  1  R handshake
- rd_req_valid / rd_req_ready  out / in  1  backend request handshake
- rd_req_addr  out  ADDR_W  beat address
- rd_req_size  out  3  beat size (= arsize)
- rd_rsp_valid  in  1  backend data valid; one-cycle pulse, no backpressure
- rd_rsp_data  in  DATA_W  read data, right-justified
- rd_rsp_resp  in  2  backend response
- busy  out  1  queue non-empty or engine not IDLE

## Operation
- AR queue: s_axi_arready = !full while out of reset. A handshake pushes {id, addr, len, size, burst}. A push and a pop in the same cycle are legal.
- FSM states: IDLE, REQ, WAIT, RESP.
- IDLE: when the queue is non-empty, pop the head, load the burst registers and beat counter = len, then go to REQ.
  - If the burst is illegal, go to RESP in error mode instead.
- REQ: hold rd_req_valid=1 with stable addr/size until rd_req_ready, then go to WAIT.
- WAIT: on rd_rsp_valid, capture replicated data and rd_rsp_resp, then go to RESP.
- RESP: hold s_axi_rvalid=1 with stable outputs until s_axi_rready.
  - On the final beat (counter==0), go to IDLE.
  - Otherwise decrement the counter, advance the address, and go to REQ (or stay in RESP in error mode).
- Only one backend request is outstanding at any time.
- Address advance, incr = 1<<size:
  - FIXED: address unchanged.
  - INCR: addr = (addr & ~(incr-1)) + incr, modulo 2^ADDR_W.
  - WRAP: bound = (len+1)*incr; addr = (addr & ~(bound-1)) | ((addr+incr) & (bound-1)).
- Illegal burst: arburst==11, or arsize > log2(DATA_W/8), or WRAP with len not in {1,3,7,15}.
  - Error mode issues no backend requests.
  - All len+1 beats return rdata=0, rresp=2'b10 (SLVERR), with correct RID and RLAST.
- Data replication:
  - size 0: byte repeated across the bus.
  - size 1: halfword repeated.
  - size 2: word repeated (64-bit bus only).
  - size 3: full width.
- s_axi_rlast=1 exactly on the beat with counter==0. A burst with len=0 gives a single beat with rlast=1.

## Timing
- While s_axi_aresetn=0, all outputs are 0: arready, rvalid, rlast, rid, rdata, rresp, rd_req_valid, rd_req_addr, rd_req_size, busy.
- Reset asserted mid-burst aborts immediately (asynchronous): queue flushed, FSM to IDLE, no further beats.
- arready rises on the first clk edge after reset release.
- AR handshake in cycle 0 (queue previously empty): rd_req_valid asserts in cycle 2.
- rd_rsp_valid in cycle n: s_axi_rvalid asserts in cycle n+1.
- Next beat: rd_req_valid asserts the cycle after the R handshake.
- Back-to-back bursts: the IDLE pop occurs the cycle after the previous rlast handshake.
- In error mode, consecutive beats are issued one per cycle while rready=1.

## Configuration
- ESAXI_RD_WRAP_EN defined: WRAP bursts are supported as described above.
- ESAXI_RD_WRAP_EN undefined: arburst==10 is classified illegal and returns SLVERR on all beats. The wrap address logic is not compiled.

## Test plan
- INCR, araddr=0x1000, len=3, size=2, backend returns 0xA0..0xA3 → rd_req_addr 0x1000/04/08/0C; rdata A0..A3; rlast only on the 4th beat; rid equals arid.
- WRAP, araddr=0x2008, len=3, size=2 (macro defined) → addresses 0x2008, 0x200C, 0x2000, 0x2004. The same burst with the macro undefined → 4 beats of rresp=10, zero backend requests.
- Narrow read, DATA_W=32, size=0, rd_rsp_data=0x5A → rdata=0x5A5A5A5A. With size=1 and data 0x1234 → rdata=0x12341234.
- AR_DEPTH=2, three AR pushed back-to-back with the first burst stalled by rready=0 → arready deasserts after two queued entries; all three bursts complete in order with correct IDs.
- FIXED burst, len=2, rready toggling 1/0 → rd_req_addr constant, rvalid/rdata held stable during stalls, exactly 3 beats.
- Reset pulsed during beat 2 of a len=7 INCR burst → rvalid=0 immediately; after release, busy=0, arready=1, and a new burst completes normally.
